// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the data-memory arbiter.
//   owner_t : which requester owns the memory port in a given cycle
//   state_t : arbiter FSM states
//   F3_*    : RV32I load/store width codes, shared with the core decoder
//   sat_inc : saturating increment used by the arbiter counters
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_C    = 2'd1,
    OWN_X    = 2'd2
  } owner_t;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_XBURST = 1'b1
  } state_t;

  // Counter width covers the 1..15 range of MAX_WAIT / MAX_BURST.
  localparam int CNT_W = 4;

  // Load width codes.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store width codes.
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                               input logic [CNT_W-1:0] limit);
    return (value >= limit) ? limit : value + 1'b1;
  endfunction

endpackage

// File: rtl/dmem_arb_select.sv
// ---------------------------------------------------------------------------
// dmem_arb_select
// Pure combinational winner selection for the data-memory arbiter.
//
// Build option (macro DMEM_ARB_RR_EN):
//   undefined : core has fixed priority; X wins once it has been denied for
//               MAX_WAIT consecutive cycles (wait_cnt == MAX_WAIT).
//   defined   : round-robin on contention, the requester that did not own
//               the port last wins.
//   In ST_XBURST the X port has absolute priority in both builds.
//
// Ports
//   state      in   current arbiter FSM state
//   c_req      in   core request
//   x_req      in   loader/DMA request
//   wait_cnt   in   X starvation counter        (fixed-priority build)
//   last_owner in   owner of the latest grant   (round-robin build)
//   owner      out  winner for this cycle, OWN_NONE when nobody requests
// ---------------------------------------------------------------------------
module dmem_arb_select
  import dmem_arb_pkg::*;
`ifndef DMEM_ARB_RR_EN
#(
  parameter int MAX_WAIT = 4
)
`endif
(
  input  state_t           state,
  input  logic             c_req,
  input  logic             x_req,
`ifdef DMEM_ARB_RR_EN
  input  owner_t           last_owner,
`else
  input  logic [CNT_W-1:0] wait_cnt,
`endif
  output owner_t           owner
);

  // NOTE: every signal written in always_comb gets a default before any
  // branch; a path that leaves it unassigned would infer a latch.
  always_comb begin
    owner = OWN_NONE;
    if (state == ST_XBURST) begin
      // The core is locked out for the whole burst.
      if (x_req) owner = OWN_X;
    end else begin
`ifdef DMEM_ARB_RR_EN
      if (c_req && x_req) owner = (last_owner == OWN_C) ? OWN_X : OWN_C;
      else if (c_req)     owner = OWN_C;
      else if (x_req)     owner = OWN_X;
`else
      if (x_req && (wait_cnt == CNT_W'(MAX_WAIT))) owner = OWN_X;
      else if (c_req)                              owner = OWN_C;
      else if (x_req)                              owner = OWN_X;
`endif
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single data-memory port between the RV32I core (C port) and a
// loader/DMA engine (X port). The RAM behind it has a synchronous read with
// one cycle of latency and uses the RV32I func3 width encoding, which is
// passed through untouched.
//
// Grants are combinational: the winner's fields drive mem_* in the same
// cycle, and a transfer completes on the clock edge where req & gnt.
// Loads return one cycle later on the issuing port's rvalid/rdata; reads
// may be issued back to back every cycle.
//
// Build option (macro DMEM_ARB_RR_EN):
//   undefined : fixed core priority with a MAX_WAIT starvation guard for X.
//   defined   : round-robin between C and X in ST_ARB (wait_cnt tied 0).
//   X bursts under x_lock behave the same in both builds.
//
// Parameters
//   ADDR_W     address width of both requesters and the memory
//   DATA_W     data width
//   MAX_WAIT   consecutive denied X cycles before X is forced to win (1..15)
//   MAX_BURST  max consecutive X beats under x_lock (1..15)
//
// Ports
//   clock                        in   rising-edge clock
//   reset                        in   asynchronous active-low reset
//   c_req/c_addr/c_write/
//   c_func3/c_wdata              in   core request, held stable until c_gnt
//   c_gnt                        out  core request issued this cycle
//   c_rvalid/c_rdata             out  core load return
//   x_req/x_addr/x_write/
//   x_func3/x_wdata              in   X request, same rules as the core
//   x_lock                       in   X asks to keep the port for next beat
//   x_gnt                        out  X request issued this cycle
//   x_rvalid/x_rdata             out  X load return
//   mem_addr/mem_write/
//   mem_func3/mem_wdata          out  memory command (all 0 when idle)
//   mem_rdata                    in   memory read data, one cycle after issue
// ---------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              c_req,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic              c_write,
  input  logic [2:0]        c_func3,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,

  input  logic              x_req,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic              x_write,
  input  logic [2:0]        x_func3,
  input  logic [DATA_W-1:0] x_wdata,
  input  logic              x_lock,
  output logic              x_gnt,
  output logic              x_rvalid,
  output logic [DATA_W-1:0] x_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [2:0]        mem_func3,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             rd_pend;
  owner_t           rd_owner;
  owner_t           sel_owner;
  owner_t           owner;

`ifdef DMEM_ARB_RR_EN
  owner_t           last_owner;

  // Round-robin mode has no starvation counter.
  assign wait_cnt = '0;
`else
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);
  logic [CNT_W-1:0] wait_nxt;
`endif

  // -------------------------------------------------------------------------
  // Winner selection
  // -------------------------------------------------------------------------
`ifdef DMEM_ARB_RR_EN
  dmem_arb_select u_select (
    .state      (state),
    .c_req      (c_req),
    .x_req      (x_req),
    .last_owner (last_owner),
    .owner      (sel_owner)
  );
`else
  dmem_arb_select #(
    .MAX_WAIT (MAX_WAIT)
  ) u_select (
    .state    (state),
    .c_req    (c_req),
    .x_req    (x_req),
    .wait_cnt (wait_cnt),
    .owner    (sel_owner)
  );
`endif

  // Grants are combinational, so they must also be forced low while reset
  // is held; otherwise a requester could see a grant that never completes.
  assign owner = reset ? sel_owner : OWN_NONE;
  assign c_gnt = (owner == OWN_C);
  assign x_gnt = (owner == OWN_X);

  // -------------------------------------------------------------------------
  // Memory command mux: the winner drives the port, an idle port is all 0.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_addr  = '0;
    mem_write = 1'b0;
    mem_func3 = 3'b000;
    mem_wdata = '0;
    unique case (owner)
      OWN_C: begin
        mem_addr  = c_addr;
        mem_write = c_write;
        mem_func3 = c_func3;
        mem_wdata = c_write ? c_wdata : '0;
      end
      OWN_X: begin
        mem_addr  = x_addr;
        mem_write = x_write;
        mem_func3 = x_func3;
        mem_wdata = x_write ? x_wdata : '0;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM next state and burst counter.
  // burst_cnt holds the number of X beats already issued in the current
  // burst, so the beat that brings the total to MAX_BURST is the last one
  // and the port goes back to ST_ARB right after it.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    unique case (state)
      ST_ARB: begin
        // With MAX_BURST == 1 the opening beat is already the whole burst.
        if (x_gnt && x_lock && (BURST_LIM > 1)) begin
          state_nxt = ST_XBURST;
          burst_nxt = CNT_W'(1);
        end
      end
      ST_XBURST: begin
        if (x_gnt && x_lock && (burst_cnt < BURST_LIM - 1'b1)) begin
          burst_nxt = burst_cnt + 1'b1;
        end else begin
          // Lock dropped, cap reached or X went idle; this cycle's beat,
          // if any, has still been issued above.
          state_nxt = ST_ARB;
          burst_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_ARB;
        burst_nxt = '0;
      end
    endcase
  end

`ifndef DMEM_ARB_RR_EN
  // Counts consecutive cycles where X asks and loses; any X grant or an
  // idle X restarts the count.
  always_comb begin
    wait_nxt = '0;
    if (x_req && !x_gnt) wait_nxt = sat_inc(wait_cnt, WAIT_LIM);
  end
`endif

  // -------------------------------------------------------------------------
  // State registers and read-return pipeline.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_ARB;
      burst_cnt <= '0;
      rd_pend   <= 1'b0;
      rd_owner  <= OWN_NONE;
`ifdef DMEM_ARB_RR_EN
      // Starting at X makes the core win the first tie.
      last_owner <= OWN_X;
`else
      wait_cnt  <= '0;
`endif
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      rd_pend   <= (owner != OWN_NONE) && !mem_write;
      rd_owner  <= owner;
`ifdef DMEM_ARB_RR_EN
      if (owner != OWN_NONE) last_owner <= owner;
`else
      wait_cnt  <= wait_nxt;
`endif
    end
  end

  // The RAM output is only routed to the port whose load is returning.
  assign c_rvalid = rd_pend && (rd_owner == OWN_C);
  assign x_rvalid = rd_pend && (rd_owner == OWN_X);
  assign c_rdata  = c_rvalid ? mem_rdata : '0;
  assign x_rdata  = x_rvalid ? mem_rdata : '0;

endmodule
